// File: rtl/dram_dma_engine_pkg.sv
// Shared types and defaults for the single-channel DRAM<->SRAM word DMA engine.
// Holds the FSM state enum, default widths, and the DRAM byte step per word.
// Imported by dram_dma_engine; no logic of its own beyond a small state helper.
package dram_dma_engine_pkg;

  localparam int DMA_ADDR_W   = 32;  // DRAM byte-address width
  localparam int DMA_DATA_W   = 32;  // data word width (DRAM and SRAM)
  localparam int DMA_SRAM_AW  = 32;  // SRAM word-address width
  localparam int DMA_LEN_W    = 16;  // word-count width
  localparam int DMA_BYTE_INC = 4;   // DRAM byte address step per word

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_DRAM = 3'd1,
    WR_SRAM = 3'd2,
    RD_SRAM = 3'd3,
    WR_DRAM = 3'd4,
    DONE    = 3'd5
  } dma_state_t;

  // States in which a word is in flight; busy follows this, so it drops
  // in the same cycle that done is raised.
  function automatic logic is_xfer_state(input dma_state_t s);
    return (s inside {RD_DRAM, WR_SRAM, RD_SRAM, WR_DRAM});
  endfunction

endpackage

// File: rtl/dram_dma_engine.sv
// Purpose: single-channel word DMA, DRAM->SRAM (load) or SRAM->DRAM (store), one word at a time.
// Latency: 2 cycles per word at zero wait; done pulses 2N+1 cycles after the accept cycle.
// Backpressure: DRAM_WaitRequest / SRAM_w_done / SRAM_d_ready stall the word in flight; cmd_ready low while busy.
//
// Ports:
//   clock, reset (async active-low)
//   cmd_valid/cmd_ready + cmd_store, cmd_dram_addr, cmd_sram_addr, cmd_len : descriptor
//   done (1-cycle pulse), busy                                             : status
//   DRAM_Read/Write/Address/WriteData, DRAM_ReadData, DRAM_WaitRequest     : DRAM master
//   SRAM_w_en/w_addr/w_d, SRAM_w_done                                      : SRAM write
//   SRAM_r_en/r_addr, SRAM_r_d, SRAM_d_ready                               : SRAM read
module dram_dma_engine
  import dram_dma_engine_pkg::*;
#(
  parameter int ADDR_W   = DMA_ADDR_W,
  parameter int DATA_W   = DMA_DATA_W,
  parameter int SRAM_AW  = DMA_SRAM_AW,
  parameter int LEN_W    = DMA_LEN_W,
  parameter int BYTE_INC = DMA_BYTE_INC
) (
  input  logic               clock,
  input  logic               reset,
  // descriptor
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_store,
  input  logic [ADDR_W-1:0]  cmd_dram_addr,
  input  logic [SRAM_AW-1:0] cmd_sram_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  // status
  output logic               done,
  output logic               busy,
  // DRAM master
  output logic               DRAM_Read,
  output logic               DRAM_Write,
  output logic [ADDR_W-1:0]  DRAM_Address,
  output logic [DATA_W-1:0]  DRAM_WriteData,
  input  logic [DATA_W-1:0]  DRAM_ReadData,
  input  logic               DRAM_WaitRequest,
  // SRAM write port
  output logic               SRAM_w_en,
  output logic [SRAM_AW-1:0] SRAM_w_addr,
  output logic [DATA_W-1:0]  SRAM_w_d,
  input  logic               SRAM_w_done,
  // SRAM read port
  output logic               SRAM_r_en,
  output logic [SRAM_AW-1:0] SRAM_r_addr,
  input  logic [DATA_W-1:0]  SRAM_r_d,
  input  logic               SRAM_d_ready
);

  dma_state_t state, next_state;

  // Working registers for the descriptor in progress. The direction is not
  // kept: it is fully encoded by which read state the FSM enters on accept.
  logic [ADDR_W-1:0]  daddr;
  logic [SRAM_AW-1:0] saddr;
  logic [LEN_W-1:0]   cnt;
  logic [DATA_W-1:0]  data_r;

  // Registered request/status outputs.
  logic cmd_ready_q, busy_q, done_q;
  logic dram_read_q, dram_write_q, sram_w_en_q, sram_r_en_q;

  // Next-cycle values of the registered outputs.
  logic cmd_ready_nxt, busy_nxt, done_nxt;
  logic dram_read_nxt, dram_write_nxt, sram_w_en_nxt, sram_r_en_nxt;

  logic last_word;
  logic word_step;

  assign last_word = (cnt == LEN_W'(1));

  // A word retires when its write half completes, in either direction.
  assign word_step = ((state == WR_SRAM) && SRAM_w_done) ||
                     ((state == WR_DRAM) && !DRAM_WaitRequest);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            next_state = DONE;
          end else if (cmd_store) begin
            next_state = RD_SRAM;
          end else begin
            next_state = RD_DRAM;
          end
        end
      end
      RD_DRAM: begin
        if (!DRAM_WaitRequest) next_state = WR_SRAM;
      end
      WR_SRAM: begin
        if (SRAM_w_done) next_state = last_word ? DONE : RD_DRAM;
      end
      RD_SRAM: begin
        if (SRAM_d_ready) next_state = WR_DRAM;
      end
      WR_DRAM: begin
        if (!DRAM_WaitRequest) next_state = last_word ? DONE : RD_SRAM;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. Decoded from next_state and registered below, so every
  // request is a flop output and drops the cycle after its handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_ready_nxt  = (next_state == IDLE);
    busy_nxt       = is_xfer_state(next_state);
    done_nxt       = (next_state == DONE);
    dram_read_nxt  = (next_state == RD_DRAM);
    dram_write_nxt = (next_state == WR_DRAM);
    sram_w_en_nxt  = (next_state == WR_SRAM);
    sram_r_en_nxt  = (next_state == RD_SRAM);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dram_read_q  <= 1'b0;
      dram_write_q <= 1'b0;
      sram_w_en_q  <= 1'b0;
      sram_r_en_q  <= 1'b0;
    end else begin
      cmd_ready_q  <= cmd_ready_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      dram_read_q  <= dram_read_nxt;
      dram_write_q <= dram_write_nxt;
      sram_w_en_q  <= sram_w_en_nxt;
      sram_r_en_q  <= sram_r_en_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: descriptor latch, data capture, per-word address/count step.
  // Address adds wrap naturally at the register width.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      daddr  <= '0;
      saddr  <= '0;
      cnt    <= '0;
      data_r <= '0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        daddr <= cmd_dram_addr;
        saddr <= cmd_sram_addr;
        cnt   <= cmd_len;
      end
      if ((state == RD_DRAM) && !DRAM_WaitRequest) begin
        data_r <= DRAM_ReadData;
      end
      if ((state == RD_SRAM) && SRAM_d_ready) begin
        data_r <= SRAM_r_d;
      end
      if (word_step) begin
        daddr <= daddr + ADDR_W'(BYTE_INC);
        saddr <= saddr + SRAM_AW'(1);
        cnt   <= cnt - LEN_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring. Address/data buses come straight from the working
  // registers, which only change on a completed handshake, so they are stable
  // for the whole life of each request.
  // ---------------------------------------------------------------------------
  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign DRAM_Read      = dram_read_q;
  assign DRAM_Write     = dram_write_q;
  assign DRAM_Address   = daddr;
  assign DRAM_WriteData = data_r;
  assign SRAM_w_en      = sram_w_en_q;
  assign SRAM_w_addr    = saddr;
  assign SRAM_w_d       = data_r;
  assign SRAM_r_en      = sram_r_en_q;
  assign SRAM_r_addr    = saddr;

endmodule

// File: tb/tb_dram_dma_engine.sv
// Bench for dram_dma_engine: memory responders with random wait states, a
// transaction log, and a reference model of the expected transfer sequence.
module tb_dram_dma_engine;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_store;
  logic [31:0] cmd_dram_addr;
  logic [31:0] cmd_sram_addr;
  logic [15:0] cmd_len;
  logic        done;
  logic        busy;
  logic        DRAM_Read;
  logic        DRAM_Write;
  logic [31:0] DRAM_Address;
  logic [31:0] DRAM_WriteData;
  logic [31:0] DRAM_ReadData;
  logic        DRAM_WaitRequest;
  logic        SRAM_w_en;
  logic [31:0] SRAM_w_addr;
  logic [31:0] SRAM_w_d;
  logic        SRAM_w_done;
  logic        SRAM_r_en;
  logic [31:0] SRAM_r_addr;
  logic [31:0] SRAM_r_d;
  logic        SRAM_d_ready;

  dram_dma_engine dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_dram_addr(cmd_dram_addr), .cmd_sram_addr(cmd_sram_addr), .cmd_len(cmd_len),
    .done(done), .busy(busy),
    .DRAM_Read(DRAM_Read), .DRAM_Write(DRAM_Write), .DRAM_Address(DRAM_Address),
    .DRAM_WriteData(DRAM_WriteData), .DRAM_ReadData(DRAM_ReadData),
    .DRAM_WaitRequest(DRAM_WaitRequest),
    .SRAM_w_en(SRAM_w_en), .SRAM_w_addr(SRAM_w_addr), .SRAM_w_d(SRAM_w_d),
    .SRAM_w_done(SRAM_w_done),
    .SRAM_r_en(SRAM_r_en), .SRAM_r_addr(SRAM_r_addr), .SRAM_r_d(SRAM_r_d),
    .SRAM_d_ready(SRAM_d_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  int checks = 0;
  int errors = 0;

  // responder knobs
  int dmin = 0, dmax = 0, smin = 0, smax = 0;
  bit noise = 0;

  // monitor state / logs
  int          ncyc = 0;
  int          proto_err = 0;
  int          req_seen = 0;
  int          wait_total = 0;
  int          sram_wr_starts = 0;
  logic [31:0] dram_rd_q[$];
  logic [31:0] sram_rd_q[$];
  xfer_t       sram_wr_q[$];
  xfer_t       dram_wr_q[$];
  int          done_q[$];
  int          ready_rise_q[$];

  // memory contents as pure functions of address
  function automatic logic [31:0] dram_val(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] sram_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} + 32'h5A5A_1234;
  endfunction

  // Responder + monitor: decides handshakes for the coming edge and logs
  // every transfer that will complete on it.
  initial begin : responder
    bit          d_pend, s_pend, d_wr_s, s_wr_s, prev_ready, fin;
    int          d_left, s_left;
    logic [31:0] d_addr_s, d_data_s, s_addr_s, s_data_s;
    d_pend = 0; s_pend = 0; d_wr_s = 0; s_wr_s = 0; prev_ready = 1;
    d_left = 0; s_left = 0;
    d_addr_s = '0; d_data_s = '0; s_addr_s = '0; s_data_s = '0;
    DRAM_WaitRequest = 0; DRAM_ReadData = '0;
    SRAM_w_done = 0; SRAM_d_ready = 0; SRAM_r_d = '0;
    forever begin
      @(negedge clock);
      ncyc++;
      if (reset !== 1'b1) begin
        d_pend = 0; s_pend = 0; prev_ready = 1;
        DRAM_WaitRequest = 0; SRAM_w_done = 0; SRAM_d_ready = 0;
      end else begin
        if (cmd_ready && !prev_ready) ready_rise_q.push_back(ncyc);
        prev_ready = cmd_ready;
        if ((DRAM_Read || DRAM_Write) && (SRAM_w_en || SRAM_r_en)) proto_err++;
        if (DRAM_Read && DRAM_Write) proto_err++;
        if (SRAM_w_en && SRAM_r_en) proto_err++;
        if (done && (busy || cmd_ready)) proto_err++;
        if (busy && cmd_ready) proto_err++;
        if ((DRAM_Read || DRAM_Write || SRAM_w_en || SRAM_r_en) && !busy) proto_err++;
        if (done === 1'b1) done_q.push_back(ncyc);
        if (DRAM_Read || DRAM_Write || SRAM_w_en || SRAM_r_en) req_seen++;

        // DRAM side
        if (DRAM_Read || DRAM_Write) begin
          if (!d_pend) begin
            d_pend = 1; d_left = $urandom_range(dmax, dmin); wait_total += d_left;
            d_addr_s = DRAM_Address; d_data_s = DRAM_WriteData; d_wr_s = DRAM_Write;
          end else if (DRAM_Write !== d_wr_s || DRAM_Address !== d_addr_s ||
                       (d_wr_s && DRAM_WriteData !== d_data_s)) begin
            proto_err++;
          end
          fin = (d_left == 0);
          if (!fin) d_left--;
          DRAM_WaitRequest = !fin;
          DRAM_ReadData = $urandom;
          if (fin) begin
            d_pend = 0;
            if (d_wr_s) dram_wr_q.push_back('{a: DRAM_Address, d: DRAM_WriteData});
            else begin
              DRAM_ReadData = dram_val(DRAM_Address);
              dram_rd_q.push_back(DRAM_Address);
            end
          end
        end else begin
          d_pend = 0;
          DRAM_WaitRequest = noise && ($urandom_range(1, 0) == 1);
          DRAM_ReadData = $urandom;
        end

        // SRAM side
        if (SRAM_w_en || SRAM_r_en) begin
          if (!s_pend) begin
            s_pend = 1; s_left = $urandom_range(smax, smin); wait_total += s_left;
            s_wr_s = SRAM_w_en; s_addr_s = SRAM_w_en ? SRAM_w_addr : SRAM_r_addr;
            s_data_s = SRAM_w_d;
            if (SRAM_w_en) sram_wr_starts++;
          end else if (SRAM_w_en !== s_wr_s ||
                       (s_wr_s ? (SRAM_w_addr !== s_addr_s || SRAM_w_d !== s_data_s)
                               : (SRAM_r_addr !== s_addr_s))) begin
            proto_err++;
          end
          fin = (s_left == 0);
          if (!fin) s_left--;
          SRAM_r_d = $urandom;
          if (s_wr_s) begin
            SRAM_w_done  = fin;
            SRAM_d_ready = noise && ($urandom_range(1, 0) == 1);
            if (fin) sram_wr_q.push_back('{a: SRAM_w_addr, d: SRAM_w_d});
          end else begin
            SRAM_d_ready = fin;
            SRAM_w_done  = noise && ($urandom_range(1, 0) == 1);
            if (fin) begin
              SRAM_r_d = sram_val(SRAM_r_addr);
              sram_rd_q.push_back(SRAM_r_addr);
            end
          end
          if (fin) s_pend = 0;
        end else begin
          s_pend = 0;
          SRAM_w_done  = noise && ($urandom_range(1, 0) == 1);
          SRAM_d_ready = noise && ($urandom_range(1, 0) == 1);
          SRAM_r_d = $urandom;
        end
      end
    end
  end

  // Reference model: word i of a load reads DRAM da+4i and writes that word
  // to SRAM sa+i; a store reads SRAM sa+i and writes it to DRAM da+4i.
  // Returns the number of log entries that disagree.
  function automatic int model_errs(input bit st, input logic [31:0] da,
                                    input logic [31:0] sa, input int n);
    int e;
    logic [31:0] ea, es;
    e = 0;
    if (st) begin
      if (sram_rd_q.size() != n || dram_wr_q.size() != n ||
          dram_rd_q.size() != 0 || sram_wr_q.size() != 0) e++;
      else for (int i = 0; i < n; i++) begin
        ea = da + 32'(4 * i);
        es = sa + 32'(i);
        if (sram_rd_q[i] !== es) e++;
        if (dram_wr_q[i].a !== ea || dram_wr_q[i].d !== sram_val(es)) e++;
      end
    end else begin
      if (dram_rd_q.size() != n || sram_wr_q.size() != n ||
          sram_rd_q.size() != 0 || dram_wr_q.size() != 0) e++;
      else for (int i = 0; i < n; i++) begin
        ea = da + 32'(4 * i);
        es = sa + 32'(i);
        if (dram_rd_q[i] !== ea) e++;
        if (sram_wr_q[i].a !== es || sram_wr_q[i].d !== dram_val(ea)) e++;
      end
    end
    return e;
  endfunction

  task automatic clear_logs();
    dram_rd_q.delete(); sram_rd_q.delete(); sram_wr_q.delete(); dram_wr_q.delete();
    done_q.delete(); ready_rise_q.delete();
    wait_total = 0; req_seen = 0; sram_wr_starts = 0;
  endtask

  // Issue one descriptor and wait for its done pulse (bounded).
  task automatic run_desc(input bit st, input logic [31:0] da, input logic [31:0] sa,
                          input logic [15:0] ln, output int acc, output bit tmo);
    int guard;
    tmo = 0; guard = 0; acc = 0;
    @(negedge clock); #1;
    while (cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge clock); #1; guard++;
    end
    if (guard >= 200) begin
      tmo = 1;
      return;
    end
    clear_logs();
    cmd_store = st; cmd_dram_addr = da; cmd_sram_addr = sa; cmd_len = ln;
    cmd_valid = 1; acc = ncyc;
    @(negedge clock); #1;
    cmd_valid = 0;
    cmd_store = 1'($urandom_range(1, 0)); cmd_dram_addr = $urandom;
    cmd_sram_addr = $urandom; cmd_len = 16'($urandom);
    guard = 0;
    while (done_q.size() == 0 && guard < 3000) begin
      @(negedge clock); #1; guard++;
    end
    if (guard >= 3000) tmo = 1;
    repeat (3) @(negedge clock);
    #1;
  endtask

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  task automatic test_reset();
    reset = 0; cmd_valid = 0; cmd_store = 0;
    cmd_dram_addr = '0; cmd_sram_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({DRAM_Read, DRAM_Write, SRAM_w_en, SRAM_r_en, done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {DRAM_Read, DRAM_Write, SRAM_w_en, SRAM_r_en, done, busy});
    end
    checks++;
    if ({DRAM_Address, DRAM_WriteData, SRAM_w_addr, SRAM_w_d, SRAM_r_addr} !== 160'b0) begin
      errors++;
      $display("FAIL reset_bus: daddr=%h wdata=%h saddr=%h want 0",
               DRAM_Address, DRAM_WriteData, SRAM_w_addr);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
    reset = 1;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_load_basic();
    int acc, p0, me;
    bit tmo;
    dmin = 0; dmax = 0; smin = 0; smax = 0; noise = 0; p0 = proto_err;
    run_desc(0, 32'h1000, 32'h10, 16'd3, acc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL load_timeout: done not seen"); end
    me = model_errs(0, 32'h1000, 32'h10, 3);
    checks++;
    if (me !== 0) begin
      errors++;
      $display("FAIL load_xfers: %0d bad entries, rd=%0d wr=%0d want 3/3",
               me, dram_rd_q.size(), sram_wr_q.size());
    end
    checks++;
    if (done_q.size() !== 1) begin
      errors++; $display("FAIL load_done_count: got %0d want 1", done_q.size());
    end
    checks++;
    if (first_done() - acc !== 7) begin
      errors++; $display("FAIL load_latency: got %0d want 7", first_done() - acc);
    end
    checks++;
    if (proto_err !== p0) begin
      errors++; $display("FAIL load_protocol: %0d violations want 0", proto_err - p0);
    end
  endtask

  task automatic test_store_wait();
    int acc, p0, me;
    bit tmo;
    dmin = 3; dmax = 3; smin = 0; smax = 0; noise = 0; p0 = proto_err;
    run_desc(1, 32'h2000, 32'h40, 16'd2, acc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL store_timeout: done not seen"); end
    me = model_errs(1, 32'h2000, 32'h40, 2);
    checks++;
    if (me !== 0) begin
      errors++;
      $display("FAIL store_xfers: %0d bad entries, srd=%0d dwr=%0d want 2/2",
               me, sram_rd_q.size(), dram_wr_q.size());
    end
    checks++;
    if (done_q.size() !== 1) begin
      errors++; $display("FAIL store_done_count: got %0d want 1", done_q.size());
    end
    // 2 words x 2 cycles + 3 wait cycles on each DRAM write + 1
    checks++;
    if (first_done() - acc !== 11) begin
      errors++; $display("FAIL store_latency: got %0d want 11", first_done() - acc);
    end
    checks++;
    if (proto_err !== p0) begin
      errors++; $display("FAIL store_stable: %0d violations want 0", proto_err - p0);
    end
  endtask

  task automatic test_len_zero();
    int acc, rr;
    bit tmo;
    dmin = 0; dmax = 0; smin = 0; smax = 0; noise = 1;
    run_desc(0, 32'h5000, 32'h50, 16'd0, acc, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL len0_timeout: done not seen"); end
    checks++;
    if (req_seen !== 0) begin
      errors++; $display("FAIL len0_requests: got %0d request cycles want 0", req_seen);
    end
    checks++;
    if (done_q.size() !== 1 || first_done() - acc !== 1) begin
      errors++;
      $display("FAIL len0_done: count=%0d delay=%0d want 1/1", done_q.size(), first_done() - acc);
    end
    rr = (ready_rise_q.size() > 0) ? ready_rise_q[0] - acc : -1;
    checks++;
    if (rr !== 2) begin
      errors++; $display("FAIL len0_ready: ready back after %0d want 2", rr);
    end
  endtask

  task automatic test_cmd_while_busy();
    int acc, me;
    bit tmo;
    logic [31:0] da, sa;
    dmin = 0; dmax = 2; smin = 0; smax = 2; noise = 1;
    da = $urandom & 32'hFFFF_FFFC; sa = $urandom;
    fork
      run_desc(0, da, sa, 16'd4, acc, tmo);
      begin
        repeat (6) @(negedge clock);
        #2;
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++; $display("FAIL busy_ready: got %b want 0", cmd_ready);
        end
        cmd_valid = 1; cmd_store = 1; cmd_len = 16'd1;
        cmd_dram_addr = 32'hBAD0_0000; cmd_sram_addr = 32'hBAD;
        repeat (3) @(negedge clock);
        #2;
        cmd_valid = 0;
      end
    join
    checks++;
    if (tmo) begin errors++; $display("FAIL busy_timeout: done not seen"); end
    me = model_errs(0, da, sa, 4);
    checks++;
    if (me !== 0) begin
      errors++; $display("FAIL busy_xfers: %0d bad entries want 0", me);
    end
    checks++;
    if (done_q.size() !== 1) begin
      errors++; $display("FAIL busy_done_count: got %0d want 1", done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int guard, acc, me;
    bit tmo;
    logic [31:0] da, sa;
    dmin = 0; dmax = 0; smin = 2; smax = 2; noise = 0;
    @(negedge clock); #1;
    clear_logs();
    cmd_store = 0; cmd_dram_addr = 32'h3000; cmd_sram_addr = 32'h80; cmd_len = 16'd4;
    cmd_valid = 1;
    @(negedge clock); #1;
    cmd_valid = 0;
    guard = 0;
    while (sram_wr_starts < 2 && guard < 100) begin
      @(negedge clock); #1; guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++; $display("FAIL rstmid_reach: word 2 write not seen, starts=%0d", sram_wr_starts);
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if ({DRAM_Read, DRAM_Write, SRAM_w_en, SRAM_r_en, done, busy} !== 6'b0 ||
        DRAM_Address !== 32'h0 || SRAM_w_addr !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: ctrl=%b daddr=%h saddr=%h want 0",
               {DRAM_Read, DRAM_Write, SRAM_w_en, SRAM_r_en, done, busy},
               DRAM_Address, SRAM_w_addr);
    end
    @(negedge clock); #1;
    reset = 1;
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || done_q.size() !== 0) begin
      errors++;
      $display("FAIL rstmid_idle: ready=%b dones=%0d want 1/0", cmd_ready, done_q.size());
    end
    smin = 0; smax = 1; dmin = 0; dmax = 1;
    da = $urandom & 32'hFFFF_FFFC; sa = $urandom;
    run_desc(0, da, sa, 16'd3, acc, tmo);
    me = model_errs(0, da, sa, 3);
    checks++;
    if (tmo || me !== 0 || done_q.size() !== 1) begin
      errors++;
      $display("FAIL rstmid_rerun: tmo=%0d bad=%0d dones=%0d want 0/0/1", tmo, me, done_q.size());
    end
  endtask

  task automatic test_wrap();
    int acc, me;
    bit tmo;
    logic [31:0] d1, s1;
    dmin = 0; dmax = 0; smin = 0; smax = 0; noise = 0;
    run_desc(0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 16'd2, acc, tmo);
    me = model_errs(0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 2);
    checks++;
    if (tmo || me !== 0) begin
      errors++; $display("FAIL wrap_xfers: tmo=%0d bad=%0d want 0/0", tmo, me);
    end
    d1 = (dram_rd_q.size() > 1) ? dram_rd_q[1] : 32'hFFFF_FFFF;
    s1 = (sram_wr_q.size() > 1) ? sram_wr_q[1].a : 32'hFFFF_FFFF;
    checks++;
    if (d1 !== 32'h0 || s1 !== 32'h0) begin
      errors++; $display("FAIL wrap_addr: dram=%h sram=%h want 00000000/00000000", d1, s1);
    end
    checks++;
    if (first_done() - acc !== 5) begin
      errors++; $display("FAIL wrap_latency: got %0d want 5", first_done() - acc);
    end
  endtask

  task automatic test_random();
    int acc, me, n, p0;
    bit tmo, st;
    logic [31:0] da, sa;
    p0 = proto_err;
    for (int it = 0; it < 30; it++) begin
      dmin = $urandom_range(1, 0); dmax = dmin + $urandom_range(3, 0);
      smin = $urandom_range(1, 0); smax = smin + $urandom_range(3, 0);
      noise = 1;
      st = 1'($urandom_range(1, 0));
      n  = $urandom_range(6, 0);
      da = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      sa = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC | ($urandom & 32'h3)) : $urandom;
      run_desc(st, da, sa, 16'(n), acc, tmo);
      me = model_errs(st, da, sa, n);
      checks++;
      if (tmo || me !== 0) begin
        errors++;
        $display("FAIL rand_xfers it=%0d st=%0d n=%0d: tmo=%0d bad=%0d want 0/0", it, st, n, tmo, me);
      end
      checks++;
      if (done_q.size() !== 1 || first_done() - acc !== 2 * n + 1 + wait_total) begin
        errors++;
        $display("FAIL rand_done it=%0d: count=%0d delay=%0d want 1/%0d",
                 it, done_q.size(), first_done() - acc, 2 * n + 1 + wait_total);
      end
    end
    checks++;
    if (proto_err !== p0) begin
      errors++; $display("FAIL rand_protocol: %0d violations want 0", proto_err - p0);
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_load_basic();
    test_store_wait();
    test_len_zero();
    test_cmd_while_busy();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
